// File: rtl/fdiv_pack_pkg.sv
// Shared binary32 field definitions, bias, canonical quiet NaN and operand classes
// for the divider result packer.
package fdiv_pack_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_INF,
      CLS_NAN,
      CLS_NORM
   } fp_class_t;

endpackage

// File: rtl/fdiv_classify.sv
// Combinational binary32 operand classifier: splits out sign and biased exponent
// and reports zero/inf/NaN/normal, treating subnormals as zero.
module fdiv_classify
   import fdiv_pack_pkg::*;
(
   input  logic [31:0]      value,
   output fp_class_t        cls,
   output logic             sign,
   output logic [EXP_W-1:0] biased_exp
);

   always_comb begin
      sign       = value[31];
      biased_exp = value[30:23];
      cls        = CLS_NORM;
      if (biased_exp == '0)
         cls = CLS_ZERO;
      else if (biased_exp == EXP_MAX)
         cls = (value[FRAC_W-1:0] != '0) ? CLS_NAN : CLS_INF;
   end

endmodule

// File: rtl/fdiv_pack.sv
// Two-stage valid/ready packer turning operands plus a divider mantissa quotient into a
// binary32 quotient with truncation and flush-to-zero. Sticky flags need FDIV_FLAGS_EN.
module fdiv_pack
   import fdiv_pack_pkg::*;
#(
   parameter int FP_DW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP_DW-1:0] div_rb,
   input  logic [FP_DW-1:0] div_rc,
   input  logic [FP_DW-1:0] div_ra,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_DW-1:0] out_ra,
   input  logic             flag_clr,
   output logic             div_lvf_flag,
   output logic             div_luf_flag,
   output logic             div_dz_flag,
   output logic             div_nv_flag
);

   fp_class_t        cls_a, cls_b;
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;

   logic             s1_valid;
   logic             s1_sign;
   logic [EXP_W-1:0] s1_ea, s1_eb;
   logic [23:0]      s1_q;
   fp_class_t        s1_cls_a, s1_cls_b;

   logic             out_adv;
   logic [9:0]       exp_raw, exp_adj;
   logic [FRAC_W-1:0] frac;
   logic [31:0]      res_ra;
   logic             res_lvf, res_luf, res_dz, res_nv;
   logic             ev_lvf, ev_luf, ev_dz, ev_nv;

   fdiv_classify u_class_a (
      .value      (div_rb),
      .cls        (cls_a),
      .sign       (sign_a),
      .biased_exp (exp_a)
   );

   fdiv_classify u_class_b (
      .value      (div_rc),
      .cls        (cls_b),
      .sign       (sign_b),
      .biased_exp (exp_b)
   );

   assign out_adv  = !out_valid || out_ready;
   assign in_ready = !s1_valid || out_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_ea    <= '0;
         s1_eb    <= '0;
         s1_q     <= '0;
         s1_cls_a <= CLS_ZERO;
         s1_cls_b <= CLS_ZERO;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= sign_a ^ sign_b;
            s1_ea    <= exp_a;
            s1_eb    <= exp_b;
            s1_q     <= div_ra[31:8];
            s1_cls_a <= cls_a;
            s1_cls_b <= cls_b;
         end
      end
   end

   // s1_q[23] is the quotient integer bit; when clear the mantissa is renormalised by one.
   always_comb begin
      exp_raw = {2'b00, s1_ea} - {2'b00, s1_eb} + 10'(BIAS);
      exp_adj = s1_q[23] ? exp_raw : exp_raw - 10'd1;
      frac    = s1_q[23] ? s1_q[22:0] : {s1_q[21:0], 1'b0};
      res_ra  = {s1_sign, exp_adj[EXP_W-1:0], frac};
      res_lvf = 1'b0;
      res_luf = 1'b0;
      res_dz  = 1'b0;
      res_nv  = 1'b0;
      if (s1_cls_a == CLS_NAN || s1_cls_b == CLS_NAN) begin
         res_ra = QNAN;
         res_nv = 1'b1;
      end else if ((s1_cls_a == CLS_ZERO && s1_cls_b == CLS_ZERO) ||
                   (s1_cls_a == CLS_INF  && s1_cls_b == CLS_INF)) begin
         res_ra = QNAN;
         res_nv = 1'b1;
      end else if (s1_cls_a == CLS_NORM && s1_cls_b == CLS_ZERO) begin
         res_ra = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
         res_dz = 1'b1;
      end else if (s1_cls_a == CLS_INF) begin
         res_ra = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
      end else if (s1_cls_a == CLS_ZERO || s1_cls_b == CLS_INF) begin
         res_ra = {s1_sign, 31'd0};
      end else if ($signed(exp_adj) >= 10'sd255) begin
         res_ra  = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
         res_lvf = 1'b1;
      end else if ($signed(exp_adj) <= 10'sd0) begin
         res_ra  = {s1_sign, 31'd0};
         res_luf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ra    <= '0;
         ev_lvf    <= 1'b0;
         ev_luf    <= 1'b0;
         ev_dz     <= 1'b0;
         ev_nv     <= 1'b0;
      end else if (out_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_ra <= res_ra;
            ev_lvf <= res_lvf;
            ev_luf <= res_luf;
            ev_dz  <= res_dz;
            ev_nv  <= res_nv;
         end
      end
   end

   logic unused_ra_low;
   assign unused_ra_low = ^div_ra[7:0];

`ifdef FDIV_FLAGS_EN
   logic out_fire;
   logic lvf_q, luf_q, dz_q, nv_q;

   assign out_fire = out_valid && out_ready;

   // Events only count once the result actually leaves; a same-cycle set beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvf_q <= 1'b0;
         luf_q <= 1'b0;
         dz_q  <= 1'b0;
         nv_q  <= 1'b0;
      end else begin
         lvf_q <= (lvf_q && !flag_clr) || (out_fire && ev_lvf);
         luf_q <= (luf_q && !flag_clr) || (out_fire && ev_luf);
         dz_q  <= (dz_q  && !flag_clr) || (out_fire && ev_dz);
         nv_q  <= (nv_q  && !flag_clr) || (out_fire && ev_nv);
      end
   end

   assign div_lvf_flag = lvf_q;
   assign div_luf_flag = luf_q;
   assign div_dz_flag  = dz_q;
   assign div_nv_flag  = nv_q;
`else
   logic unused_flag_path;
   assign unused_flag_path = ^{flag_clr, ev_lvf, ev_luf, ev_dz, ev_nv};

   assign div_lvf_flag = 1'b0;
   assign div_luf_flag = 1'b0;
   assign div_dz_flag  = 1'b0;
   assign div_nv_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_pack.sv
// Scoreboard bench for fdiv_pack: directed known-answer cases, backpressure,
// reset flush and randomised operands; flag expectations follow FDIV_FLAGS_EN.
module tb_fdiv_pack;
   import fdiv_pack_pkg::*;

`ifdef FDIV_FLAGS_EN
   localparam logic [31:0] FL = 32'd1;
`else
   localparam logic [31:0] FL = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] div_rb, div_rc, div_ra;
   logic        out_valid, out_ready;
   logic [31:0] out_ra;
   logic        flag_clr;
   logic        div_lvf_flag, div_luf_flag, div_dz_flag, div_nv_flag;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] sb_q[$];
   bit          hold_armed = 1'b0;
   logic [31:0] held_ra;
   bit          random_on;

   fdiv_pack #(.FP_DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .div_rb       (div_rb),
      .div_rc       (div_rc),
      .div_ra       (div_ra),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ra       (out_ra),
      .flag_clr     (flag_clr),
      .div_lvf_flag (div_lvf_flag),
      .div_luf_flag (div_luf_flag),
      .div_dz_flag  (div_dz_flag),
      .div_nv_flag  (div_nv_flag)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic int op_class(input logic [31:0] x);
      if (x[30:23] == 8'h00) return 0;
      if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? 2 : 1;
      return 3;
   endfunction

   // Reference: 0=zero, 1=inf, 2=NaN, 3=normal
   function automatic logic [31:0] model(input logic [31:0] rb, input logic [31:0] rc, input logic [31:0] ra);
      int          ca, cb, e;
      logic        s;
      logic [22:0] f;
      ca = op_class(rb);
      cb = op_class(rc);
      s  = rb[31] ^ rc[31];
      if (ca == 2 || cb == 2) return QNAN;
      if ((ca == 0 && cb == 0) || (ca == 1 && cb == 1)) return QNAN;
      if (cb == 0 && ca == 3) return {s, 8'hFF, 23'd0};
      if (ca == 1) return {s, 8'hFF, 23'd0};
      if (ca == 0 || cb == 1) return {s, 31'd0};
      e = int'(rb[30:23]) - int'(rc[30:23]) + 127;
      if (ra[31]) f = ra[30:8];
      else begin
         e = e - 1;
         f = {ra[29:8], 1'b0};
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, 8'(e), f};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
         0: return {s, 31'd0};
         1: return {s, 8'hFF, 23'd0};
         2: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         3: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
         default: return {s, 8'($urandom_range(1, 254)), 23'($urandom_range(0, 32'h7FFFFF))};
      endcase
   endfunction

   // Monitor: pops on each transfer and checks hold stability while stalled.
   always @(negedge clk) begin
      if (rst) begin
         hold_armed = 1'b0;
      end else begin
         if (hold_armed) begin
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_data", out_ra, held_ra);
         end
         if (out_valid && out_ready) begin
            checkOutput("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) checkOutput("sb_data", out_ra, sb_q.pop_front());
         end
         hold_armed = out_valid && !out_ready;
         held_ra    = out_ra;
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [31:0] rb, input logic [31:0] rc, input logic [31:0] ra,
                                input logic [31:0] expected);
      bit acc = 1'b0;
      int budget = 0;
      div_rb   = rb;
      div_rc   = rc;
      div_ra   = ra;
      in_valid = 1'b1;
      while (!acc && budget < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      in_valid = 1'b0;
      if (acc) sb_q.push_back(expected);
      else checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic waitDrain();
      int c = 0;
      while (sb_q.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain", 32'(sb_q.size()), 32'd0);
   endtask

   function automatic logic [31:0] flag_vec();
      return {28'd0, div_lvf_flag, div_luf_flag, div_dz_flag, div_nv_flag};
   endfunction

   logic [31:0] spec_tbl [7][4] = '{
      '{32'h7F800000, 32'h40000000, 32'h80000000, 32'h7F800000},
      '{32'h40000000, 32'hFF800000, 32'h80000000, 32'h80000000},
      '{32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000},
      '{32'h7F800001, 32'h3F800000, 32'h80000000, 32'h7FC00000},
      '{32'h7F800000, 32'h7F800000, 32'h80000000, 32'h7FC00000},
      '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7F800000},
      '{32'h00000001, 32'h3F800000, 32'h80000000, 32'h00000000}
   };

   initial begin
      logic [31:0] a, b, q;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flag_clr  = 1'b0;
      div_rb    = '0;
      div_rc    = '0;
      div_ra    = '0;

      @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_ra", out_ra, 32'd0);
      checkOutput("rst_flags", flag_vec(), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 6.0 / 2.0 with latency check
      applyStimulus(32'h40C00000, 32'h40000000, 32'hC0000000, 32'h40400000);
      checkOutput("lat_early", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("lat_data", out_ra, 32'h40400000);
      waitDrain();
      checkOutput("flags_clean", flag_vec(), 32'd0);

      applyStimulus(32'h3F800000, 32'h3FC00000, 32'h55555500, 32'h3F2AAAAA);
      waitDrain();

      // overflow, sticky until cleared
      applyStimulus(32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000);
      waitDrain();
      checkOutput("lvf_set", {31'd0, div_lvf_flag}, FL);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("lvf_sticky", {31'd0, div_lvf_flag}, FL);
      flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;
      checkOutput("lvf_cleared", flag_vec(), 32'd0);

      applyStimulus(32'h3F800000, 32'h00000000, 32'h80000000, 32'h7F800000);
      waitDrain();
      checkOutput("dz_set", {31'd0, div_dz_flag}, FL);
      applyStimulus(32'h00000000, 32'h00000000, 32'h80000000, 32'h7FC00000);
      waitDrain();
      checkOutput("nv_set", {31'd0, div_nv_flag}, FL);
      applyStimulus(32'h00800000, 32'h7F000000, 32'h80000000, 32'h00000000);
      waitDrain();
      checkOutput("luf_set", {31'd0, div_luf_flag}, FL);
      checkOutput("flags_accum", flag_vec(), {28'd0, FL[0], FL[0], FL[0], FL[0]});

      // clear asserted on the transfer cycle of an overflow: set wins, others clear
      applyStimulus(32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000);
      @(posedge clk);
      #1 flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;
      checkOutput("clr_vs_set", flag_vec(), {28'd0, FL[0], 3'b000});
      waitDrain();
      flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;

      for (int i = 0; i < 7; i++)
         applyStimulus(spec_tbl[i][0], spec_tbl[i][1], spec_tbl[i][2], spec_tbl[i][3]);
      waitDrain();

      // backpressure: two accepts fill the pipe, the third waits
      out_ready = 1'b0;
      applyStimulus(32'h40C00000, 32'h40000000, 32'hC0000000, 32'h40400000);
      applyStimulus(32'h3F800000, 32'h3FC00000, 32'h55555500, 32'h3F2AAAAA);
      div_rb   = 32'h3F800000;
      div_rc   = 32'h3F800000;
      div_ra   = 32'h80000000;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_in_ready0", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp_in_ready1", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      applyStimulus(32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000);
      waitDrain();

      // reset with both stages full
      out_ready = 1'b0;
      applyStimulus(32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000);
      applyStimulus(32'h40C00000, 32'h40000000, 32'hC0000000, 32'h40400000);
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_flags", flag_vec(), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("post_rst_no_out", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // random operands under random backpressure
      random_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               a = rnd_op();
               b = rnd_op();
               q = $urandom();
               applyStimulus(a, b, q, model(a, b, q));
            end
            random_on = 1'b0;
         end
         begin
            while (random_on) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fdiv_pack.md
FDIV_PACK -- requirements
Module: fdiv_pack

Interface
REQ-001 Parameter FP_DW, default 32: operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  operand pair and quotient word valid.
REQ-005 in_ready  out  1  block accepts this cycle.
REQ-006 div_rb  in  FP_DW  dividend, binary32.
REQ-007 div_rc  in  FP_DW  divisor, binary32.
REQ-008 div_ra  in  FP_DW  mantissa quotient word from the divider: [31] integer bit, [30:8] fraction (Q1.23), [7:0] ignored.
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 out_ra  out  FP_DW  packed binary32 quotient.
REQ-012 flag_clr  in  1  clears sticky flags.
REQ-013 div_lvf_flag, div_luf_flag, div_dz_flag, div_nv_flag  out  1 each  sticky overflow, underflow, divide-by-zero and invalid flags.

Function
REQ-014 Two-stage valid/ready pipeline; latency exactly 2 cycles from accept to out_valid with no stall; throughput 1 per cycle.
REQ-015 Transfer occurs on valid&&ready; a stage advances when empty or when its successor advances; in_ready = !s1_valid || s1 advances.
REQ-016 out_valid, out_ra held stable while out_valid && !out_ready; no loss, duplication or reordering.
REQ-017 Stage 1 registers sign = rb[31]^rc[31], biased exponents, the quotient word, and per-operand class (zero, inf, NaN, normal); exponent 0 (subnormal) classes as zero.
REQ-018 Stage 2: exponent e = ea - eb + 127 in 10-bit signed arithmetic; if div_ra[31]=0, e = e-1 and fraction = div_ra[29:8]<<1 (LSB 0), else fraction = div_ra[30:8].
REQ-019 Rounding is truncation; no round bit is consumed.
REQ-020 If e >= 255: result ±inf (sign,0xFF,0), overflow event.
REQ-021 If e <= 0: result ±0, underflow event (flush-to-zero).
REQ-022 Specials, priority order: either NaN -> 0x7FC00000, invalid; 0/0 or inf/inf -> 0x7FC00000, invalid; finite nonzero / 0 -> ±inf, div-by-zero; inf/finite -> ±inf; 0/nonzero or finite/inf -> ±0; specials override REQ-020/021.
REQ-023 Events set sticky flags only when the result transfers out (out_valid && out_ready).
REQ-024 flag_clr clears all flags; clear and a same-cycle set: set wins.

Reset
REQ-025 On rst: s1_valid, out_valid, all flags = 0; out_ra = 0; in_ready = 1 from the first cycle after release.
REQ-026 Reset mid-operation discards all in-flight results; nothing emitted after release until a new accept.

Configuration
REQ-027 Macro FDIV_FLAGS_EN: defined -> REQ-023/024 flag logic is present; undefined -> all four flag outputs are tied to 0 and flag_clr is ignored; datapath is identical in both cases.

Structure
REQ-028 A shared package holds the binary32 field widths, bias (127), the canonical qNaN constant, and the operand-class enum.
REQ-029 One sub-module, fdiv_classify (combinational: binary32 -> class, sign, exponent), is instantiated twice in stage 1.

Verification
REQ-030 rb=0x40C00000, rc=0x40000000, div_ra=0xC0000000 -> out_ra=0x40400000 two cycles later; no flags.
REQ-031 rb=0x3F800000, rc=0x3FC00000, div_ra=0x55555500 -> out_ra=0x3F2AAAAA.
REQ-032 rb=0x7F000000, rc=0x00800000, div_ra=0x80000000 -> out_ra=0x7F800000, div_lvf_flag=1 until flag_clr.
REQ-033 rb=0x3F800000, rc=0x00000000 -> 0x7F800000, dz=1; rb=rc=0 -> 0x7FC00000, nv=1.
REQ-034 Three back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after two accepts; the three results emerge in order, unchanged.
REQ-035 rst pulsed with both stages full -> out_valid=0 next cycle, flags 0, no stale result emitted.
